// File: rtl/vga_pkg.sv
// vga_pkg
//   Shared definitions for the VGA raster path, used by the timing generator and
//   by the downstream reset-blanking output stage.
//   Contents: RGB333 pixel type, 640x480@60 default timing, sync polarity
//   constants, counter width and a helper that turns a sync flag into a pin level.
package vga_pkg;

  typedef logic [8:0] rgb333_t;

  localparam int unsigned CNT_W = 10;

  localparam int unsigned VGA_H_ACTIVE = 640;
  localparam int unsigned VGA_H_FP     = 16;
  localparam int unsigned VGA_H_SYNC   = 96;
  localparam int unsigned VGA_H_BP     = 48;
  localparam int unsigned VGA_V_ACTIVE = 480;
  localparam int unsigned VGA_V_FP     = 10;
  localparam int unsigned VGA_V_SYNC   = 2;
  localparam int unsigned VGA_V_BP     = 33;

  localparam bit POL_ACTIVE_LOW  = 1'b0;
  localparam bit POL_ACTIVE_HIGH = 1'b1;
  localparam bit VGA_HSYNC_POL   = POL_ACTIVE_LOW;
  localparam bit VGA_VSYNC_POL   = POL_ACTIVE_LOW;

  // Pin level for a sync signal: the active level when asserted, its inverse otherwise.
  function automatic logic sync_level(input logic pol, input logic asserted);
    return asserted ? pol : ~pol;
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// vga_timing_gen_if
//   Pixel fetch bus between the timing generator and the frame source.
//   pix_req  : fetch request, active-area only
//   pix_x/y  : requested column/line, valid while pix_req
//   pix_rgb  : RGB333 returned by the source a fixed latency after pix_req
//   master = timing generator, slave = frame source.
interface vga_timing_gen_if;
  import vga_pkg::*;

  logic             pix_req;
  logic [CNT_W-1:0] pix_x;
  logic [CNT_W-1:0] pix_y;
  rgb333_t          pix_rgb;

  modport master (output pix_req, output pix_x, output pix_y, input pix_rgb);
  modport slave  (input pix_req, input pix_x, input pix_y, output pix_rgb);

endinterface

// File: rtl/vga_delay_line.sv
// vga_delay_line
//   Fixed-depth shift register with a programmable reset value.
//   Parameters: WIDTH (bits per stage), DEPTH (stages, >= 1), RST_VAL.
//   Ports:
//     clk    : clock, rising edge
//     rst_n  : asynchronous active-low reset, loads RST_VAL into every stage
//     d_i    : data in
//     q_o    : data in delayed by DEPTH clocks
module vga_delay_line #(
  parameter int unsigned          WIDTH   = 3,
  parameter int unsigned          DEPTH   = 2,
  parameter logic [WIDTH-1:0]     RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] stage_q [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= RST_VAL;
    end else begin
      stage_q[0] <= d_i;
      for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen
//   Pixel-clock VGA raster timing generator and pixel aligner. Runs the H/V
//   counters, requests pixels from the frame source PIPE_LAT cycles ahead and
//   re-aligns the returned pixel with delayed de/hsync/vsync so that all outputs
//   leave one register stage together, PIPE_LAT+1 cycles after the counter state.
//   Ports:
//     clk_pixel : pixel clock, rising edge
//     reset_n   : asynchronous active-low reset
//     enable    : run raster; low clears and holds counters at (0,0)
//     pix_bus   : fetch bus (master) - pix_req/pix_x/pix_y out, pix_rgb in
//     rgb       : aligned RGB333, 0 outside active video
//     hsync     : horizontal sync, level HSYNC_POL when asserted
//     vsync     : vertical sync, level VSYNC_POL when asserted
//     de        : data enable
//     frame_start : only with VGA_TIMING_FRAME_STROBE_EN defined; one-cycle
//                   pulse with the output pixel at (0,0)
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE  = VGA_H_ACTIVE,
  parameter int unsigned H_FP      = VGA_H_FP,
  parameter int unsigned H_SYNC    = VGA_H_SYNC,
  parameter int unsigned H_BP      = VGA_H_BP,
  parameter int unsigned V_ACTIVE  = VGA_V_ACTIVE,
  parameter int unsigned V_FP      = VGA_V_FP,
  parameter int unsigned V_SYNC    = VGA_V_SYNC,
  parameter int unsigned V_BP      = VGA_V_BP,
  parameter bit          HSYNC_POL = VGA_HSYNC_POL,
  parameter bit          VSYNC_POL = VGA_VSYNC_POL,
  parameter int unsigned PIPE_LAT  = 2
) (
  input  logic             clk_pixel,
  input  logic             reset_n,
  input  logic             enable,
  vga_timing_gen_if.master pix_bus,
  output rgb333_t          rgb,
  output logic             hsync,
  output logic             vsync,
  output logic             de
`ifdef VGA_TIMING_FRAME_STROBE_EN
  ,
  output logic             frame_start
`endif
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT_C  = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT_C  = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  localparam int unsigned F_VS    = 0;
  localparam int unsigned F_HS    = 1;
  localparam int unsigned F_ACT   = 2;
`ifdef VGA_TIMING_FRAME_STROBE_EN
  localparam int unsigned F_FIRST = 3;
  localparam int unsigned FLAG_W  = 4;
`else
  localparam int unsigned FLAG_W  = 3;
`endif

  if (H_FP == 0 || H_SYNC == 0 || H_BP == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0) begin : g_bad_porch
    $error("vga_timing_gen: porch and sync widths must be non-zero");
  end
  if (PIPE_LAT < 1 || PIPE_LAT > 8) begin : g_bad_lat
    $error("vga_timing_gen: PIPE_LAT must be 1..8");
  end
  if (H_TOTAL > (1 << CNT_W) || V_TOTAL > (1 << CNT_W)) begin : g_bad_total
    $error("vga_timing_gen: raster totals exceed the counter width");
  end

  logic [CNT_W-1:0] h_q, h_d, v_q, v_d;
  logic             run;
  logic             active_c, hs_c, vs_c;
  logic [FLAG_W-1:0] flags_c, flags_dly;
  rgb333_t          rgb_q;
  logic             hsync_q, vsync_q, de_q;

  // reset_n is folded in so pix_req stays low while reset holds the counters at (0,0).
  assign run = enable & reset_n;

  always_comb begin
    h_d = h_q;
    v_d = v_q;
    if (!enable) begin
      h_d = '0;
      v_d = '0;
    end else if (h_q == H_LAST) begin
      h_d = '0;
      v_d = (v_q == V_LAST) ? '0 : v_q + CNT_W'(1);
    end else begin
      h_d = h_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      h_q <= '0;
      v_q <= '0;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
    end
  end

  // Flags are gated by run so the cycle in which enable drops already feeds
  // inactive entries into the pipeline, matching the withdrawn pix_req.
  assign active_c = run && (h_q < H_ACT_C) && (v_q < V_ACT_C);
  assign hs_c     = run && (h_q >= HS_START) && (h_q < HS_END);
  assign vs_c     = run && (v_q >= VS_START) && (v_q < VS_END);

  assign pix_bus.pix_req = active_c;
  assign pix_bus.pix_x   = active_c ? h_q : '0;
  assign pix_bus.pix_y   = active_c ? v_q : '0;

  always_comb begin
    flags_c        = '0;
    flags_c[F_ACT] = active_c;
    flags_c[F_HS]  = hs_c;
    flags_c[F_VS]  = vs_c;
`ifdef VGA_TIMING_FRAME_STROBE_EN
    flags_c[F_FIRST] = run && (h_q == '0) && (v_q == '0);
`endif
  end

  vga_delay_line #(
    .WIDTH   (FLAG_W),
    .DEPTH   (PIPE_LAT),
    .RST_VAL (FLAG_W'(0))
  ) u_flag_dly (
    .clk   (clk_pixel),
    .rst_n (reset_n),
    .d_i   (flags_c),
    .q_o   (flags_dly)
  );

  // Delayed flags now line up with pix_rgb; register both together so every
  // output changes on the same edge.
  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      rgb_q   <= '0;
      de_q    <= 1'b0;
      hsync_q <= ~HSYNC_POL;
      vsync_q <= ~VSYNC_POL;
    end else begin
      rgb_q   <= flags_dly[F_ACT] ? pix_bus.pix_rgb : '0;
      de_q    <= flags_dly[F_ACT];
      hsync_q <= sync_level(HSYNC_POL, flags_dly[F_HS]);
      vsync_q <= sync_level(VSYNC_POL, flags_dly[F_VS]);
    end
  end

  assign rgb   = rgb_q;
  assign de    = de_q;
  assign hsync = hsync_q;
  assign vsync = vsync_q;

`ifdef VGA_TIMING_FRAME_STROBE_EN
  logic frame_start_q;

  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) frame_start_q <= 1'b0;
    else          frame_start_q <= flags_dly[F_FIRST];
  end

  assign frame_start = frame_start_q;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen
//   Self-checking bench for vga_timing_gen on a reduced raster (25x15 totals)
//   with PIPE_LAT=2. A behavioural counter model pushes the expected output of
//   each cycle into a queue that is popped PIPE_LAT+1 cycles later; the bench
//   also acts as the frame source, answering each request two cycles later.
module tb_vga_timing_gen;
  import vga_pkg::*;

  localparam int HA = 16, HFP = 2, HSW = 3, HBP = 4;
  localparam int VA = 8,  VFP = 2, VSW = 2, VBP = 3;
  localparam int LAT = 2;
  localparam int HT = HA + HFP + HSW + HBP;
  localparam int VT = VA + VFP + VSW + VBP;

  typedef struct packed {
    logic    de;
    rgb333_t rgb;
    logic    hs;
    logic    vs;
    logic    fs;
  } expT;

  logic    clk_pixel = 1'b0;
  logic    reset_n   = 1'b0;
  logic    enable    = 1'b0;
  rgb333_t rgb;
  logic    hsync, vsync, de;
`ifdef VGA_TIMING_FRAME_STROBE_EN
  logic    frame_start;
`endif

  vga_timing_gen_if pixBus();

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .PIPE_LAT(LAT)
  ) dut (
    .clk_pixel (clk_pixel),
    .reset_n   (reset_n),
    .enable    (enable),
    .pix_bus   (pixBus),
    .rgb       (rgb),
    .hsync     (hsync),
    .vsync     (vsync),
    .de        (de)
`ifdef VGA_TIMING_FRAME_STROBE_EN
    ,
    .frame_start (frame_start)
`endif
  );

  always #5 clk_pixel = ~clk_pixel;

  int  testCount = 0;
  int  failCount = 0;
  int  mh = 0, mv = 0;
  bit  men = 0;
  int  cyc = 0;
  int  firstDeCyc = -1;
  int  deCount = 0, hsLow = 0, vsLow = 0, fsCount = 0;
  expT expQ[$];
  logic       h1Req = 0, h2Req = 0;
  logic [9:0] h1X = '0, h1Y = '0, h2X = '0, h2Y = '0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic expT modelOut(input int h, input int v, input bit en);
    expT e;
    bit  act, hsA, vsA;
    act   = en && h < HA && v < VA;
    hsA   = en && h >= HA + HFP && h < HA + HFP + HSW;
    vsA   = en && v >= VA + VFP && v < VA + VFP + VSW;
    e.de  = act;
    e.rgb = act ? {3'(h), 3'(v), 3'b101} : 9'h000;
    e.hs  = ~hsA;
    e.vs  = ~vsA;
    e.fs  = en && h == 0 && v == 0;
    return e;
  endfunction

  function automatic expT inactiveOut();
    expT e;
    e.de = 1'b0; e.rgb = 9'h000; e.hs = 1'b1; e.vs = 1'b1; e.fs = 1'b0;
    return e;
  endfunction

  // Model state restarts at (0,0) with an empty pipeline after reset release.
  task automatic resetModel();
    mh = 0;
    mv = 0;
    h1Req = 0;
    h2Req = 0;
    expQ.delete();
    for (int i = 0; i < LAT + 1; i++) expQ.push_back(inactiveOut());
  endtask

  // One pixel clock: entered and left at posedge+1.
  task automatic applyStimulus();
    expT want;
    bit  reqExp;
    men = enable;
    #1;
    if (expQ.size() == 0) begin
      testCount++;
      failCount++;
      $error("[TB] FAIL scoreboard: observed empty queue expected entry");
    end else begin
      want = expQ.pop_front();
      checkOutput("de",    32'(de),    32'(want.de));
      checkOutput("rgb",   32'(rgb),   32'(want.rgb));
      checkOutput("hsync", 32'(hsync), 32'(want.hs));
      checkOutput("vsync", 32'(vsync), 32'(want.vs));
`ifdef VGA_TIMING_FRAME_STROBE_EN
      checkOutput("frame_start", 32'(frame_start), 32'(want.fs));
`endif
    end
    reqExp = men && mh < HA && mv < VA;
    checkOutput("pix_req", 32'(pixBus.pix_req), 32'(reqExp));
    checkOutput("pix_x",   32'(pixBus.pix_x),   reqExp ? 32'(mh) : 32'd0);
    checkOutput("pix_y",   32'(pixBus.pix_y),   reqExp ? 32'(mv) : 32'd0);

    if (de === 1'b1) begin
      deCount++;
      if (firstDeCyc < 0) firstDeCyc = cyc;
    end
    if (hsync === 1'b0) hsLow++;
    if (vsync === 1'b0) vsLow++;
`ifdef VGA_TIMING_FRAME_STROBE_EN
    if (frame_start === 1'b1) fsCount++;
`endif

    // Frame source: answer the request from two cycles ago, garbage otherwise.
    if (h2Req) pixBus.pix_rgb = {h2X[2:0], h2Y[2:0], 3'b101};
    else       pixBus.pix_rgb = 9'($urandom);
    h2Req = h1Req; h2X = h1X; h2Y = h1Y;
    h1Req = pixBus.pix_req; h1X = pixBus.pix_x; h1Y = pixBus.pix_y;

    expQ.push_back(modelOut(mh, mv, men));

    if (!men) begin
      mh = 0;
      mv = 0;
    end else if (mh == HT - 1) begin
      mh = 0;
      mv = (mv == VT - 1) ? 0 : mv + 1;
    end else begin
      mh++;
    end
    cyc++;
    @(posedge clk_pixel);
    #1;
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, " de"},      32'(de),             32'd0);
    checkOutput({tag, " rgb"},     32'(rgb),            32'd0);
    checkOutput({tag, " hsync"},   32'(hsync),          32'd1);
    checkOutput({tag, " vsync"},   32'(vsync),          32'd1);
    checkOutput({tag, " pix_req"}, 32'(pixBus.pix_req), 32'd0);
`ifdef VGA_TIMING_FRAME_STROBE_EN
    checkOutput({tag, " frame_start"}, 32'(frame_start), 32'd0);
`endif
  endtask

  initial begin
    int enableCyc;
    int guard;

    pixBus.pix_rgb = '0;
    reset_n = 1'b0;
    enable  = 1'b0;
    repeat (3) @(posedge clk_pixel);
    #1;
    checkResetOutputs("reset");

    resetModel();
    reset_n = 1'b1;
    repeat (5) applyStimulus();

    // Enable and run two full frames; first de must appear LAT+1 cycles later.
    enable = 1'b1;
    enableCyc = cyc;
    firstDeCyc = -1;
    deCount = 0; hsLow = 0; vsLow = 0; fsCount = 0;
    repeat (2 * HT * VT + LAT + 1) applyStimulus();
    checkOutput("first de latency", 32'(firstDeCyc - enableCyc), 32'(LAT + 1));
    checkOutput("de count 2 frames",    32'(deCount), 32'(2 * HA * VA));
    checkOutput("hsync low 2 frames",   32'(hsLow),   32'(2 * VT * HSW));
    checkOutput("vsync low 2 frames",   32'(vsLow),   32'(2 * VSW * HT));
`ifdef VGA_TIMING_FRAME_STROBE_EN
    checkOutput("frame_start count", 32'(fsCount), 32'd2);
`endif

    // Drop enable mid-line, mid-frame.
    guard = 0;
    while (!(mh == 10 && mv == 5) && guard < 2 * HT * VT) begin
      applyStimulus();
      guard++;
    end
    checkOutput("reach drop point", 32'(guard < 2 * HT * VT), 32'd1);
    enable = 1'b0;
    repeat (LAT + 2) applyStimulus();
    checkResetOutputs("disabled");
    repeat (3) applyStimulus();

    // Re-enable: scoreboard expects a restart at (0,0).
    enable = 1'b1;
    repeat (60) applyStimulus();

    // Async reset between edges while active pixels are on the output.
    guard = 0;
    while (!(mh == 6 && mv == 2) && guard < 2 * HT * VT) begin
      applyStimulus();
      guard++;
    end
    checkOutput("reach reset point", 32'(guard < 2 * HT * VT), 32'd1);
    checkOutput("de before reset", 32'(de), 32'd1);
    #3;
    reset_n = 1'b0;
    #1;
    checkResetOutputs("async reset");
    repeat (2) @(posedge clk_pixel);
    #1;
    checkResetOutputs("held reset");
    resetModel();
    reset_n = 1'b1;
    repeat (HT * 3) applyStimulus();

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
